soc_sysid_arbiter: RTL

//  Shares the read-only system-ID slave (addr 0 = ID word, addr 1 = build timestamp) among N Avalon-MM

---
 rtl/soc_sysid_pkg.sv | 24 ++
 rtl/soc_rr_arbiter.sv | 49 ++++
 rtl/soc_sysid_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/soc_sysid_pkg.sv
`default_nettype none
// ============================================================================
// Module   : soc_sysid_pkg
// Purpose  : Shared types and constants for the system-ID arbiter slice.
//            State encoding of the arbiter FSM and the two word addresses
//            exposed by the sysid slave.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package soc_sysid_pkg;

  typedef enum logic [2:0] {
    BOOT_RD  = 3'd0,
    BOOT_CHK = 3'd1,
    IDLE     = 3'd2,
    ACCESS   = 3'd3,
    RESP     = 3'd4
  } state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;  // ID word
  localparam logic SYSID_ADDR_TS = 1'b1;  // build timestamp

endpackage
`default_nettype wire

// File: rtl/soc_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : soc_rr_arbiter
// Purpose  : Combinational round-robin picker. Selects the first requester
//            after the last-granted index, wrapping around.
// Ports    : req        in  NUM_MASTERS  request vector
//            last_grant in  IDX_W        index granted most recently
//            grant      out NUM_MASTERS  one-hot winner (zero when no request)
//            grant_idx  out IDX_W        binary index of the winner
//            any_req    out 1            at least one request pending
// Revision : 1.0 - initial release
// ============================================================================
module soc_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last_grant,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   any_req
);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = |req;
    w_sum     = '0;
    w_cand    = '0;
    // Walk from the farthest candidate to the nearest one so that the
    // nearest requester after last_grant is the value left standing.
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      w_sum = {1'b0, last_grant} + (IDX_W+1)'(i);
      if (w_sum >= (IDX_W+1)'(NUM_MASTERS)) begin
        w_sum = w_sum - (IDX_W+1)'(NUM_MASTERS);
      end
      w_cand = w_sum[IDX_W-1:0];
      if (req[w_cand]) begin
        grant_idx = w_cand;
      end
    end
    grant[grant_idx] = any_req;
  end

endmodule
`default_nettype wire

// File: rtl/soc_sysid_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : soc_sysid_arbiter
// Purpose  : Shares the read-only sysid slave among NUM_MASTERS Avalon-MM
//            read masters. Round-robin, one transaction in flight,
//            registered read data (request -> accept +1 -> data +2).
//            Optional boot self-check of the ID word, enabled by defining
//            the macro SOC_SYSID_ARB_BOOTCHECK_EN.
// Ports    : clock, reset_n            clock / synchronous active-low reset
//            m_read, m_address         per-master request and word address
//            m_waitrequest             per-master stall (low = accepted)
//            m_readdatavalid           one-cycle pulse to granted master
//            m_readdata                shared response data
//            s_address, s_readdata     sysid slave side
//            id_ok, id_err             sticky boot-check result
// Revision : 1.0 - initial release
// ============================================================================
module soc_sysid_arbiter
  import soc_sysid_pkg::*;
#(
  parameter int              NUM_MASTERS  = 2,
  parameter int              DATA_W       = 32,
  parameter logic [DATA_W-1:0] EXPECTED_ID = '0,
  parameter int              BOOT_RETRIES = 3
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_MASTERS-1:0] m_read,
  input  logic [NUM_MASTERS-1:0] m_address,
  output logic [NUM_MASTERS-1:0] m_waitrequest,
  output logic [NUM_MASTERS-1:0] m_readdatavalid,
  output logic [DATA_W-1:0]      m_readdata,
  output logic                   s_address,
  input  logic [DATA_W-1:0]      s_readdata,
  output logic                   id_ok,
  output logic                   id_err
);

  localparam int IDX_W = $clog2(NUM_MASTERS);

`ifdef SOC_SYSID_ARB_BOOTCHECK_EN
  localparam state_t c_reset_state = BOOT_RD;
`else
  localparam state_t c_reset_state = IDLE;
`endif

  state_t                   r_state;
  state_t                   w_next_state;
  logic [IDX_W-1:0]         r_grant_idx;
  logic [IDX_W-1:0]         r_rr_ptr;
  logic [DATA_W-1:0]        r_data;
  logic                     r_s_address;
  logic [NUM_MASTERS-1:0]   w_win_onehot;
  logic [IDX_W-1:0]         w_win_idx;
  logic                     w_any_req;

  soc_rr_arbiter #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_rr_arbiter (
    .req        (m_read),
    .last_grant (r_rr_ptr),
    .grant      (w_win_onehot),
    .grant_idx  (w_win_idx),
    .any_req    (w_any_req)
  );

`ifdef SOC_SYSID_ARB_BOOTCHECK_EN
  localparam logic [3:0] c_retries = 4'(BOOT_RETRIES);

  logic [DATA_W-1:0] r_boot_word;
  logic [3:0]        r_retry_cnt;
  logic              r_id_ok;
  logic              r_id_err;
  logic              w_boot_match;

  assign w_boot_match = (r_boot_word == EXPECTED_ID);

  // Boot capture uses its own register so m_readdata keeps its reset value
  // until the first real response.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_boot_word <= '0;
      r_retry_cnt <= '0;
      r_id_ok     <= 1'b0;
      r_id_err    <= 1'b0;
    end else begin
      case (r_state)
        BOOT_RD:  r_boot_word <= s_readdata;
        BOOT_CHK: begin
          if (w_boot_match)                    r_id_ok     <= 1'b1;
          else if (r_retry_cnt == c_retries)   r_id_err    <= 1'b1;
          else                                 r_retry_cnt <= r_retry_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign id_ok  = r_id_ok;
  assign id_err = r_id_err;
`else
  logic w_unused_params;
  assign w_unused_params = ^{EXPECTED_ID, 4'(BOOT_RETRIES)};
  assign id_ok  = 1'b1;
  assign id_err = 1'b0;
`endif

  // State register plus the datapath registers that follow it. s_address
  // stays at the ID word through the boot phase because it is only
  // rewritten when IDLE accepts a request.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= c_reset_state;
      r_grant_idx <= '0;
      r_rr_ptr    <= IDX_W'(NUM_MASTERS - 1);
      r_data      <= '0;
      r_s_address <= SYSID_ADDR_ID;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_grant_idx <= w_win_idx;
            r_rr_ptr    <= w_win_idx;
            r_s_address <= (|(m_address & w_win_onehot)) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
          end
        end
        ACCESS:  r_data <= s_readdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next_state    = r_state;
    m_waitrequest   = '1;
    m_readdatavalid = '0;
    case (r_state)
`ifdef SOC_SYSID_ARB_BOOTCHECK_EN
      BOOT_RD:  w_next_state = BOOT_CHK;
      BOOT_CHK: begin
        if (w_boot_match || (r_retry_cnt == c_retries)) w_next_state = IDLE;
        else                                            w_next_state = BOOT_RD;
      end
`endif
      IDLE: begin
        if (w_any_req) w_next_state = ACCESS;
      end
      ACCESS: begin
        m_waitrequest[r_grant_idx] = 1'b0;
        w_next_state               = RESP;
      end
      RESP: begin
        m_readdatavalid[r_grant_idx] = 1'b1;
        w_next_state                 = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign m_readdata = r_data;
  assign s_address  = r_s_address;

endmodule
`default_nettype wire
